// File: rtl/store_drain_buffer_pkg.sv
// Shared store-buffer types: access-size encodings, the buffered entry layout and drain FSM states.
// The load unit uses the same SZ_* encodings.
package store_drain_buffer_pkg;

  localparam int ROB_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [29:0]      waddr;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic [ROB_W-1:0] rob;
  } sb_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } drain_state_t;

endpackage

// File: rtl/store_drain_buffer_if.sv
// Bundle of the commit, dmem write, load-check and status signals of the store drain buffer.
interface store_drain_buffer_if
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             commit_valid;
  logic             commit_ready;
  logic [31:0]      commit_addr;
  logic [31:0]      commit_data;
  logic [1:0]       commit_size;
  logic [ROB_W-1:0] commit_rob;

  logic             mem_wr_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_ack;

  logic             ld_query_valid;
  logic [31:0]      ld_query_addr;
  logic [1:0]       ld_query_size;
  logic             ld_conflict;
  logic             ld_hit;
  logic [31:0]      ld_data;

  logic             drained;
  logic [CW-1:0]    count;

  modport slave (
    input  commit_valid, commit_addr, commit_data, commit_size, commit_rob,
    input  mem_ack, ld_query_valid, ld_query_addr, ld_query_size,
    output commit_ready, mem_wr_en, mem_addr, mem_wdata, mem_be,
    output ld_conflict, ld_hit, ld_data, drained, count
  );

  modport master (
    output commit_valid, commit_addr, commit_data, commit_size, commit_rob,
    output mem_ack, ld_query_valid, ld_query_addr, ld_query_size,
    input  commit_ready, mem_wr_en, mem_addr, mem_wdata, mem_be,
    input  ld_conflict, ld_hit, ld_data, drained, count
  );

endinterface

// File: rtl/store_drain_buffer_sb_lane_encode.sv
// Combinational lane encoder: byte enables and lane-replicated data from address offset and size.
module sb_lane_encode
  import store_drain_buffer_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  always_comb begin
    be    = 4'hF;
    wdata = data;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{data[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = data;
      end
    endcase
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Post-commit store FIFO draining to dmem one store per acked cycle; write request 1 cycle after enqueue,
// commit stalls at DEPTH entries. `STORE_BUF_FWD_EN adds youngest-entry load forwarding.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                 clk,
  input  logic                 reset,
  store_drain_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sb_entry_t         ent [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     cnt;
  drain_state_t      state, state_nxt;

  logic [3:0]        st_be, ld_be;
  logic [31:0]       st_wdata, ld_wdata_unused;
  logic [ROB_W-1:0]  head_rob_unused;
  logic              enq, pop;
  logic [DEPTH-1:0]  ovl;

  sb_lane_encode u_st_enc (
    .addr_lo (bus.commit_addr[1:0]),
    .size    (bus.commit_size),
    .data    (bus.commit_data),
    .be      (st_be),
    .wdata   (st_wdata)
  );

  sb_lane_encode u_ld_enc (
    .addr_lo (bus.ld_query_addr[1:0]),
    .size    (bus.ld_query_size),
    .data    (32'h0),
    .be      (ld_be),
    .wdata   (ld_wdata_unused)
  );

  // No bypass: a drain completing this cycle does not free a slot for this cycle's commit.
  assign bus.commit_ready = (cnt < DEPTH_C);
  assign enq = bus.commit_valid && bus.commit_ready;
  assign pop = (state == ST_WRITE) && bus.mem_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
      if (enq) begin
        ent[tail] <= '{waddr: bus.commit_addr[31:2], wdata: st_wdata,
                       be: st_be, rob: bus.commit_rob};
        tail      <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({enq, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cnt != '0 || enq) state_nxt = ST_WRITE;
      ST_WRITE: if (pop && cnt == CW'(1) && !enq) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mem_wr_en = (state == ST_WRITE);
  assign bus.mem_addr  = bus.mem_wr_en ? {ent[head].waddr, 2'b00} : 32'h0;
  assign bus.mem_wdata = bus.mem_wr_en ? ent[head].wdata : 32'h0;
  assign bus.mem_be    = bus.mem_wr_en ? ent[head].be : 4'h0;
  assign bus.drained   = (cnt == '0) && (state == ST_IDLE);
  assign bus.count     = cnt;
  assign head_rob_unused = ent[head].rob;

  // ovl is indexed by age: bit 0 is the head (oldest, possibly in flight to dmem).
  always_comb begin
    ovl = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ovl[k] = (CW'(k) < cnt)
            && (ent[head + PW'(k)].waddr == bus.ld_query_addr[31:2])
            && ((ent[head + PW'(k)].be & ld_be) != 4'h0);
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [3:0]  y_be;
  logic [31:0] y_data;

  always_comb begin
    y_be   = 4'h0;
    y_data = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ovl[k]) begin
        y_be   = ent[head + PW'(k)].be;
        y_data = ent[head + PW'(k)].wdata;
      end
    end
  end

  always_comb begin
    bus.ld_hit      = 1'b0;
    bus.ld_conflict = 1'b0;
    bus.ld_data     = 32'h0;
    if (bus.ld_query_valid && (ovl != '0)) begin
      if ((y_be & ld_be) == ld_be) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = y_data & {{8{y_be[3]}}, {8{y_be[2]}}, {8{y_be[1]}}, {8{y_be[0]}}};
      end else begin
        bus.ld_conflict = 1'b1;
      end
    end
  end
`else
  assign bus.ld_hit      = 1'b0;
  assign bus.ld_data     = 32'h0;
  assign bus.ld_conflict = bus.ld_query_valid && (ovl != '0);
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: drain timing, lane encoding, backpressure, load check, reset.
module tb_store_drain_buffer;
  import store_drain_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  store_drain_buffer_if #(.DEPTH(4)) bus ();

  store_drain_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.commit_valid = 1'b1;
    bus.commit_addr  = a;
    bus.commit_data  = d;
    bus.commit_size  = sz;
    bus.commit_rob   = a[5:2];
  endtask

  task automatic drive_query(input logic v, input logic [31:0] a, input logic [1:0] sz);
    bus.ld_query_valid = v;
    bus.ld_query_addr  = a;
    bus.ld_query_size  = sz;
    #1;
  endtask

  task automatic apply_reset();
    bus.commit_valid = 1'b0;
    bus.mem_ack      = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.commit_valid = 1'b0; bus.commit_addr = '0; bus.commit_data = '0;
    bus.commit_size = SZ_WORD; bus.commit_rob = '0; bus.mem_ack = 1'b0;
    bus.ld_query_valid = 1'b0; bus.ld_query_addr = '0; bus.ld_query_size = SZ_WORD;
    apply_reset();
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count); end
    checks++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL rst_drained got %b want 1", bus.drained); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", bus.mem_wr_en); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got %h/%h/%h want 0", bus.mem_addr, bus.mem_be, bus.mem_wdata); end
    checks++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.commit_ready); end
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b0) begin errors++; $display("FAIL rst_ld got hit=%b conf=%b want 0/0", bus.ld_hit, bus.ld_conflict); end
  endtask

  task automatic test_word_store();
    bus.mem_ack = 1'b1;
    drive_store(32'h1000, 32'hDEADBEEF, SZ_WORD);
    tick();
    bus.commit_valid = 1'b0;
    checks++; if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL word_wr_en got %b want 1", bus.mem_wr_en); end
    checks++; if (bus.mem_be !== 4'hF) begin errors++; $display("FAIL word_be got %h want f", bus.mem_be); end
    checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL word_addr got %h want 1000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wdata got %h want deadbeef", bus.mem_wdata); end
    checks++; if (bus.drained !== 1'b0) begin errors++; $display("FAIL word_busy got drained=%b want 0", bus.drained); end
    tick();
    checks++; if (bus.mem_wr_en !== 1'b0 || bus.drained !== 1'b1) begin errors++; $display("FAIL word_done got wr_en=%b drained=%b want 0/1", bus.mem_wr_en, bus.drained); end
  endtask

  task automatic test_byte_store();
    bus.mem_ack = 1'b1;
    drive_store(32'h2003, 32'h000000AB, SZ_BYTE);
    tick();
    bus.commit_valid = 1'b0;
    checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL byte_be got %b want 1000", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL byte_wdata got %h want abababab", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h2000) begin errors++; $display("FAIL byte_addr got %h want 2000", bus.mem_addr); end
    tick();
    checks++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL byte_drained got %b want 1", bus.drained); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h108; exp_addr[1] = 32'h10C; exp_addr[2] = 32'h110;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), SZ_WORD);
      tick();
    end
    checks++; if (bus.commit_ready !== 1'b0 || bus.count !== 3'd4) begin errors++; $display("FAIL full_state got ready=%b count=%0d want 0/4", bus.commit_ready, bus.count); end
    drive_store(32'h110, 32'hA4, SZ_WORD);
    tick();
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_hold_count got %0d want 4", bus.count); end
    checks++; if (bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hA0) begin errors++; $display("FAIL full_hold_head got %h/%h want 100/a0", bus.mem_addr, bus.mem_wdata); end
    // full + commit_valid + ack in one cycle: pop only
    bus.mem_ack = 1'b1;
    tick();
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_ack_count got %0d want 3", bus.count); end
    checks++; if (bus.mem_addr !== 32'h104 || bus.mem_wdata !== 32'hA1) begin errors++; $display("FAIL order_1 got %h/%h want 104/a1", bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack = 1'b0;
    tick();
    bus.commit_valid = 1'b0;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fifth_enq_count got %0d want 4", bus.count); end
    checks++; if (bus.mem_addr !== 32'h104) begin errors++; $display("FAIL order_1_hold got %h want 104", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.mem_addr !== exp_addr[i] || bus.mem_wdata !== 32'hA2 + 32'(i)) begin errors++; $display("FAIL order_%0d got %h/%h want %h/%h", i + 2, bus.mem_addr, bus.mem_wdata, exp_addr[i], 32'hA2 + 32'(i)); end
    end
    tick();
    checks++; if (bus.drained !== 1'b1 || bus.count !== 3'd0) begin errors++; $display("FAIL bp_drained got %b count=%0d want 1/0", bus.drained, bus.count); end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_load_check();
    bus.mem_ack = 1'b0;
    drive_store(32'h3000, 32'h11223344, SZ_WORD);
    tick();
    drive_store(32'h3002, 32'h0000AAAA, SZ_HALF);
    tick();
    bus.commit_valid = 1'b0;
    drive_query(1'b1, 32'h3002, SZ_HALF);
`ifdef STORE_BUF_FWD_EN
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_conflict !== 1'b0 || bus.ld_data !== 32'hAAAA0000) begin errors++; $display("FAIL ld_half got hit=%b conf=%b data=%h want 1/0/aaaa0000", bus.ld_hit, bus.ld_conflict, bus.ld_data); end
`else
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b1 || bus.ld_data !== 32'h0) begin errors++; $display("FAIL ld_half got hit=%b conf=%b data=%h want 0/1/0", bus.ld_hit, bus.ld_conflict, bus.ld_data); end
`endif
    drive_query(1'b1, 32'h3000, SZ_WORD);
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b1) begin errors++; $display("FAIL ld_word got hit=%b conf=%b want 0/1", bus.ld_hit, bus.ld_conflict); end
    drive_query(1'b1, 32'h3001, SZ_BYTE);
`ifdef STORE_BUF_FWD_EN
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_conflict !== 1'b0 || bus.ld_data !== 32'h11223344) begin errors++; $display("FAIL ld_old_byte got hit=%b conf=%b data=%h want 1/0/11223344", bus.ld_hit, bus.ld_conflict, bus.ld_data); end
`else
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b1) begin errors++; $display("FAIL ld_old_byte got hit=%b conf=%b want 0/1", bus.ld_hit, bus.ld_conflict); end
`endif
    drive_query(1'b1, 32'h3004, SZ_WORD);
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b0) begin errors++; $display("FAIL ld_miss got hit=%b conf=%b want 0/0", bus.ld_hit, bus.ld_conflict); end
    drive_query(1'b0, 32'h3000, SZ_WORD);
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b0 || bus.ld_data !== 32'h0) begin errors++; $display("FAIL ld_idle got hit=%b conf=%b data=%h want 0/0/0", bus.ld_hit, bus.ld_conflict, bus.ld_data); end
    apply_reset();
  endtask

  task automatic test_reset_mid_write();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h500 + 32'(4 * i), 32'h55 + 32'(i), SZ_WORD);
      tick();
    end
    bus.commit_valid = 1'b0;
    checks++; if (bus.mem_wr_en !== 1'b1 || bus.count !== 3'd3) begin errors++; $display("FAIL pre_rst got wr_en=%b count=%0d want 1/3", bus.mem_wr_en, bus.count); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (bus.mem_wr_en !== 1'b0 || bus.count !== 3'd0 || bus.drained !== 1'b1) begin errors++; $display("FAIL mid_rst got wr_en=%b count=%0d drained=%b want 0/0/1", bus.mem_wr_en, bus.count, bus.drained); end
    drive_store(32'h4000, 32'h0000005A, SZ_BYTE);
    tick();
    bus.commit_valid = 1'b0;
    drive_query(1'b1, 32'h4001, SZ_BYTE);
    checks++; if (bus.ld_conflict !== 1'b0 || bus.ld_hit !== 1'b0) begin errors++; $display("FAIL ld_other_lane got conf=%b hit=%b want 0/0", bus.ld_conflict, bus.ld_hit); end
    drive_query(1'b1, 32'h4000, SZ_BYTE);
`ifdef STORE_BUF_FWD_EN
    checks++; if (bus.ld_hit !== 1'b1 || bus.ld_conflict !== 1'b0 || bus.ld_data !== 32'h0000005A) begin errors++; $display("FAIL ld_same_lane got hit=%b conf=%b data=%h want 1/0/0000005a", bus.ld_hit, bus.ld_conflict, bus.ld_data); end
`else
    checks++; if (bus.ld_hit !== 1'b0 || bus.ld_conflict !== 1'b1) begin errors++; $display("FAIL ld_same_lane got hit=%b conf=%b want 0/1", bus.ld_hit, bus.ld_conflict); end
`endif
    drive_query(1'b0, 32'h0, SZ_WORD);
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_backpressure();
    test_load_check();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
